// File: rtl/demux1to2_rv32i.sv
// Buffered 1-to-2 demultiplexer: one valid/ready producer steered by in_sel into two
// independent FIFOs. Define DEMUX_STATS_EN to add saturating per-output push counters.
module demux1to2_rv32i #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [$clog2(DEPTH):0]   out0_count,
  output logic [WIDTH-1:0]         out1_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [$clog2(DEPTH):0]   out1_count
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]              stat0,
  output logic [15:0]              stat1
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic             ready_arr [2];
  logic [WIDTH-1:0] head_arr  [2];
  logic [CW-1:0]    count_arr [2];
  logic             valid_arr [2];

  assign ready_arr[0] = out0_ready;
  assign ready_arr[1] = out1_ready;

  // No bypass: a full FIFO refuses a push even when it is popped in the same cycle.
  assign in_ready = (count_arr[in_sel] != FULL);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    wr_ptr_reg;
      logic [PW-1:0]    rd_ptr_reg;
      logic [CW-1:0]    count_reg;
      logic             push;
      logic             pop;

      assign push = in_valid && in_ready && (in_sel == 1'(gi));
      assign pop  = (count_reg != '0) && ready_arr[gi];

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else begin
          if (push) begin
            mem[wr_ptr_reg] <= in_data;
            wr_ptr_reg      <= wr_ptr_reg + PW'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
          end
          if (push && !pop) begin
            count_reg <= count_reg + CW'(1);
          end else if (!push && pop) begin
            count_reg <= count_reg - CW'(1);
          end
        end
      end

      assign head_arr[gi]  = mem[rd_ptr_reg];
      assign count_arr[gi] = count_reg;
      assign valid_arr[gi] = (count_reg != '0);

`ifdef DEMUX_STATS_EN
      logic [15:0] stat_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          stat_reg <= '0;
        end else if (push && (stat_reg != 16'hFFFF)) begin
          stat_reg <= stat_reg + 16'd1;
        end
      end
`endif
    end
  endgenerate

  assign out0_data  = head_arr[0];
  assign out0_valid = valid_arr[0];
  assign out0_count = count_arr[0];
  assign out1_data  = head_arr[1];
  assign out1_valid = valid_arr[1];
  assign out1_count = count_arr[1];

`ifdef DEMUX_STATS_EN
  assign stat0 = g_fifo[0].stat_reg;
  assign stat1 = g_fifo[1].stat_reg;
`endif

endmodule

// File: tb/tb_demux1to2_rv32i.sv
// Self-checking bench for demux1to2_rv32i: directed vector table, reset corner cases,
// and randomized traffic against a queue-based reference model.
module tb_demux1to2_rv32i;

  localparam int DEPTH = 2;

  logic        clock;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [1:0]  out0_count;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [1:0]  out1_count;
`ifdef DEMUX_STATS_EN
  logic [15:0] stat0;
  logic [15:0] stat1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  demux1to2_rv32i #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_count (out0_count),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_count (out1_count)
`ifdef DEMUX_STATS_EN
    ,
    .stat0      (stat0),
    .stat1      (stat1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic        sel;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    logic        rdy;
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl [15];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic [31:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid0"}, 32'(out0_valid), 32'd0);
    check({tag, "_valid1"}, 32'(out1_valid), 32'd0);
    check({tag, "_count0"}, 32'(out0_count), 32'd0);
    check({tag, "_count1"}, 32'(out1_count), 32'd0);
    check({tag, "_data0"},  out0_data, 32'd0);
    check({tag, "_data1"},  out1_data, 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Reset asserted and released away from clock edges; inputs idle.
  task automatic do_reset();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_empty("reset");
    #2 reset_n = 1'b1;
  endtask

  initial begin
    logic exp_rdy;
    logic pop0;
    logic pop1;
    logic push;

    tbl[0]  = '{1'b1, 1'b0, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 32'hAAAAAAAA, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h55555555, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 32'hAAAAAAAA, 32'h55555555};
    tbl[2]  = '{1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 32'hAAAAAAAA, 32'h55555555};
    tbl[3]  = '{1'b1, 1'b0, 32'hABCDEF01, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 32'hAAAAAAAA, 32'h55555555};
    tbl[4]  = '{1'b1, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 32'hAAAAAAAA, 32'h55555555};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 32'h12345678, 32'h11111111};
    tbl[6]  = '{1'b1, 1'b0, 32'hABCDEF01, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 32'h12345678, 32'h11111111};
    tbl[7]  = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 32'hABCDEF01, 32'h11111111};
    tbl[8]  = '{1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 32'hCAFEF00D, 32'h11111111};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 32'h0,        32'h0};
    tbl[10] = '{1'b1, 1'b1, 32'h87654321, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 32'h0,        32'h87654321};
    tbl[11] = '{1'b1, 1'b1, 32'hFEDCBA98, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 32'h0,        32'hFEDCBA98};
    tbl[12] = '{1'b1, 1'b1, 32'h0000000F, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 32'h0,        32'h0000000F};
    tbl[13] = '{1'b1, 1'b1, 32'h000000F0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 32'h0,        32'h000000F0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 32'h0,        32'h0};

    do_reset();

    // Directed table: in_ready checked before the edge, state checked after it.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_count0", i), 32'(out0_count), 32'(tbl[i].c0));
      check($sformatf("vec%0d_count1", i), 32'(out1_count), 32'(tbl[i].c1));
      check($sformatf("vec%0d_valid0", i), 32'(out0_valid), 32'(tbl[i].c0 != 2'd0));
      check($sformatf("vec%0d_valid1", i), 32'(out1_valid), 32'(tbl[i].c1 != 2'd0));
      if (tbl[i].c0 != 2'd0) check($sformatf("vec%0d_data0", i), out0_data, tbl[i].d0);
      if (tbl[i].c1 != 2'd0) check($sformatf("vec%0d_data1", i), out1_data, tbl[i].d1);
      $display("vec %0d: v=%0b sel=%0b d=%h r0=%0b r1=%0b -> c0=%0d c1=%0d d0=%h d1=%h",
               i, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1,
               out0_count, out1_count, out0_data, out1_data);
    end

    // Fill both FIFOs, then assert reset between clock edges.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i % 2), 32'hF00D0000 + 32'(i), 1'b0, 1'b0);
      @(posedge clock);
      #1;
    end
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("fill_count0", 32'(out0_count), 32'd2);
    check("fill_count1", 32'(out1_count), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check_empty("midreset");
    $display("midreset: c0=%0d c1=%0d v0=%0b v1=%0b", out0_count, out1_count, out0_valid, out1_valid);
    #3 reset_n = 1'b1;
    drive(1'b1, 1'b1, 32'h0BADC0DE, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check("post_reset_push_count1", 32'(out1_count), 32'd1);
    check("post_reset_push_data1", out1_data, 32'h0BADC0DE);
    check("post_reset_push_count0", 32'(out0_count), 32'd0);
    $display("post-reset push: c1=%0d d1=%h", out1_count, out1_data);

    // Randomized traffic against a pair of reference queues.
    do_reset();
    q0.delete();
    q1.delete();
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
            1'($urandom), 1'($urandom_range(0, 2) == 0));
      #1;
      exp_rdy = in_sel ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
      check($sformatf("rand%0d_in_ready", n), 32'(in_ready), 32'(exp_rdy));
      check($sformatf("rand%0d_count0", n), 32'(out0_count), 32'(q0.size()));
      check($sformatf("rand%0d_count1", n), 32'(out1_count), 32'(q1.size()));
      check($sformatf("rand%0d_valid0", n), 32'(out0_valid), 32'(q0.size() != 0));
      check($sformatf("rand%0d_valid1", n), 32'(out1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) check($sformatf("rand%0d_data0", n), out0_data, q0[0]);
      if (q1.size() != 0) check($sformatf("rand%0d_data1", n), out1_data, q1[0]);
      pop0 = out0_ready && (q0.size() != 0);
      pop1 = out1_ready && (q1.size() != 0);
      push = in_valid && exp_rdy;
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (push) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
      $display("rand %0d: v=%0b sel=%0b d=%h r0=%0b r1=%0b push=%0b pop0=%0b pop1=%0b",
               n, in_valid, in_sel, in_data, out0_ready, out1_ready, push, pop0, pop1);
      @(posedge clock);
      #1;
    end
    check("rand_final_count0", 32'(out0_count), 32'(q0.size()));
    check("rand_final_count1", 32'(out1_count), 32'(q1.size()));

`ifdef DEMUX_STATS_EN
    do_reset();
    check("stat0_reset", 32'(stat0), 32'd0);
    check("stat1_reset", 32'(stat1), 32'd0);
    drive(1'b1, 1'b0, 32'h1, 1'b1, 1'b0);
    for (int n = 0; n < 70000; n++) begin
      @(posedge clock);
    end
    #1;
    drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("stat0_saturated", 32'(stat0), 32'hFFFF);
    check("stat1_idle", 32'(stat1), 32'd0);
    $display("stats: stat0=%h stat1=%h", stat0, stat1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
